// File: rtl/spartan2pram.sv
// Spartan-bus slave bridging read/write bursts onto a pipelined dual-port RAM.
// Read data returns through a credit-limited response FIFO so SpSRDY stalls never drop RAM data.
module spartan2pram #(
  parameter int BWIDTH = 64,
  parameter int RD_LAT = 1,
  parameter int FDEPTH = RD_LAT + 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BWIDTH+1:0] SpMBUS,
  input  logic              SpMVLD,
  output logic              SpMRDY,
  output logic [BWIDTH+1:0] SpSBUS,
  output logic              SpSVLD,
  input  logic              SpSRDY,
  output logic              RD,
  output logic [31:0]       RD_ADDR,
  input  logic [BWIDTH-1:0] RD_DATA,
  output logic              WR,
  output logic [31:0]       WR_ADDR,
  output logic [BWIDTH-1:0] MASK,
  output logic [BWIDTH-1:0] WR_DATA
);

  // state  | meaning
  // IDLE   | waiting for a read or write header
  // WDATA  | accepting write data beats until a last beat
  // WRESP  | presenting the write response until SpSRDY
  // RBURST | issuing RAM reads while credits allow
  // RDRAIN | all reads issued, waiting for pipeline and FIFO to empty
  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RBURST, RDRAIN} state_t;

  localparam int NB      = BWIDTH / 8;
  localparam int INC     = NB;
  localparam int LOG_INC = $clog2(INC);
  localparam int IDLO    = 41;
  localparam int IDHI    = BWIDTH - NB - 1;
  localparam int IDW     = IDHI - IDLO + 1;
  localparam int PW      = $clog2(FDEPTH);
  localparam int CW      = $clog2(FDEPTH + 1);
  localparam int EW      = BWIDTH + 2;

  state_t state, state_next;

  logic [31:0]     addr, addr_next, addr_inc, wrap_mask;
  logic [1:0]      mode;
  logic [3:0]      len;
  logic [IDW-1:0]  id;
  logic [NB-1:0]   bmask;
  logic            first;
  logic [4:0]      remaining;
  logic [4:0]      beats;
  logic            wrap_pow2;

  logic [1:0]        req_type;
  logic [BWIDTH-1:0] req_id_payload, rsp_id_payload, mask_first;

  logic [EW-1:0]   fifo_mem [FDEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count, inflight;
  logic [CW:0]     occupancy;
  logic            fifo_full, fifo_empty, credit_ok;
  logic            hdr_push, ret_push, push, pop;
  logic [EW-1:0]   push_data;

  logic [RD_LAT-1:0] sr_vld, sr_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_type   = SpMBUS[BWIDTH+1:BWIDTH];
  assign fifo_full  = (fifo_count == CW'(FDEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok  = (occupancy < (CW+1)'(FDEPTH));

  // Wrap only applies to power-of-two beat counts; otherwise it degrades to increment.
  assign beats     = {1'b0, len} + 5'd1;
  assign wrap_pow2 = ((beats & (beats - 5'd1)) == 5'd0);
  assign wrap_mask = (32'(beats) << LOG_INC) - 32'd1;
  assign addr_inc  = addr + 32'(INC);

  always_comb begin
    addr_next = addr_inc;
    case (mode)
      2'b00:   addr_next = addr;
      2'b10:   addr_next = wrap_pow2 ? ((addr & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
      default: addr_next = addr_inc;
    endcase
  end

  always_comb begin
    req_id_payload = '0;
    req_id_payload[IDHI:IDLO] = SpMBUS[IDHI:IDLO];
    rsp_id_payload = '0;
    rsp_id_payload[IDHI:IDLO] = id;
    mask_first = '0;
    for (int b = 0; b < NB; b++) mask_first[b*8 +: 8] = {8{bmask[b]}};
  end

  assign MASK    = first ? mask_first : '1;
  assign WR_DATA = SpMBUS[BWIDTH-1:0];
  assign RD_ADDR = addr;
  assign WR_ADDR = addr;

  always_comb begin
    state_next = state;
    SpMRDY     = 1'b0;
    SpSVLD     = 1'b0;
    SpSBUS     = fifo_mem[rd_ptr];
    RD         = 1'b0;
    WR         = 1'b0;
    hdr_push   = 1'b0;
    case (state)
      IDLE: begin
        if (SpMVLD) begin
          if (req_type == 2'b01) begin
            SpMRDY     = 1'b1;
            state_next = WDATA;
          end else if (req_type == 2'b00 && !fifo_full) begin
            SpMRDY     = 1'b1;
            hdr_push   = 1'b1;
            state_next = RBURST;
          end
        end
      end
      WDATA: begin
        if (SpMVLD && req_type[1]) begin
          SpMRDY = 1'b1;
          WR     = 1'b1;
          if (req_type[0]) state_next = WRESP;
        end
      end
      WRESP: begin
        SpSVLD = 1'b1;
        SpSBUS = {2'b00, rsp_id_payload};
        if (SpSRDY) state_next = IDLE;
      end
      RBURST: begin
        SpSVLD = !fifo_empty;
        RD     = credit_ok;
        if (credit_ok && remaining == 5'd1) state_next = RDRAIN;
      end
      RDRAIN: begin
        SpSVLD = !fifo_empty;
        if (inflight == '0 && fifo_empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop       = (state == RBURST || state == RDRAIN) && SpSVLD && SpSRDY;
  assign ret_push  = sr_vld[RD_LAT-1];
  assign push      = hdr_push | ret_push;
  assign push_data = hdr_push ? {2'b01, req_id_payload} : {1'b1, sr_last[RD_LAT-1], RD_DATA};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr       <= '0;
      mode       <= '0;
      len        <= '0;
      id         <= '0;
      bmask      <= '0;
      first      <= 1'b0;
      remaining  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      sr_vld     <= '0;
      sr_last    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && SpMRDY) begin
        addr      <= SpMBUS[31:0];
        len       <= SpMBUS[35:32];
        mode      <= SpMBUS[40:39];
        id        <= SpMBUS[IDHI:IDLO];
        bmask     <= SpMBUS[BWIDTH-1:BWIDTH-NB];
        first     <= 1'b1;
        remaining <= {1'b0, SpMBUS[35:32]} + 5'd1;
      end else if (WR) begin
        addr  <= addr_next;
        first <= 1'b0;
      end else if (RD) begin
        addr      <= addr_next;
        remaining <= remaining - 5'd1;
      end
      sr_vld[0]  <= RD;
      sr_last[0] <= RD && (remaining == 5'd1);
      for (int i = 1; i < RD_LAT; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_last[i] <= sr_last[i-1];
      end
      case ({RD, ret_push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_spartan2pram.sv
// Scoreboard bench for spartan2pram: stimulus queues expected responses/RAM accesses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_spartan2pram;
  localparam int BW  = 64;
  localparam int LAT = 3;
  localparam int FD  = LAT + 2;

  logic          CLK, RST;
  logic [BW+1:0] SpMBUS, SpSBUS;
  logic          SpMVLD, SpMRDY, SpSVLD, SpSRDY;
  logic          RD, WR;
  logic [31:0]   RD_ADDR, WR_ADDR;
  logic [BW-1:0] RD_DATA, MASK, WR_DATA;

  spartan2pram #(.BWIDTH(BW), .RD_LAT(LAT), .FDEPTH(FD)) dut (
    .CLK(CLK), .RST(RST),
    .SpMBUS(SpMBUS), .SpMVLD(SpMVLD), .SpMRDY(SpMRDY),
    .SpSBUS(SpSBUS), .SpSVLD(SpSVLD), .SpSRDY(SpSRDY),
    .RD(RD), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .WR(WR), .WR_ADDR(WR_ADDR), .MASK(MASK), .WR_DATA(WR_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int issued = 0, popped = 0;
  int first_c = 0, last_c = 0;
  bit seen_data = 0;
  bit hold = 0;
  logic [BW+1:0] hold_bus;

  logic [BW+1:0] sbq[$];
  logic [31:0]   rdq[$];
  logic [159:0]  wrq[$];
  logic [32:0]   hist[LAT+1];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event/timeout expected none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] ram(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A};
  endfunction

  function automatic logic [63:0] id_pay(input logic [14:0] id);
    return {8'h00, id, 41'b0};
  endfunction

  function automatic logic [65:0] hdr(input logic [1:0] typ, input logic [31:0] a, input logic [3:0] len,
                                      input logic [1:0] mode, input logic [14:0] id, input logic [7:0] bm);
    return {typ, bm, id, mode, 3'b000, len, a};
  endfunction

  // Address of beat k computed directly from the burst rule, not iterated.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] mode,
                                            input logic [3:0] len, input int k);
    int unsigned n;
    logic [31:0] w;
    n = 32'(len) + 1;
    if (mode == 2'b00) return a;
    if (mode == 2'b10 && (n & (n - 1)) == 0) begin
      w = n * 8;
      return (a & ~(w - 32'd1)) | ((a + 32'(k * 8)) & (w - 32'd1));
    end
    return a + 32'(k * 8);
  endfunction

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0: SpSRDY = 1'b1;
      1: SpSRDY = 1'($urandom_range(0, 1));
      2: SpSRDY = 1'b0;
      default: SpSRDY = ~SpSRDY;
    endcase
  end

  // RAM model: data for a read appears RD_LAT cycles later; garbage otherwise.
  initial for (int i = 0; i <= LAT; i++) hist[i] = '0;
  always @(negedge CLK) begin
    for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {RD, RD_ADDR};
    RD_DATA = hist[LAT][32] ? ram(hist[LAT][31:0]) : {$urandom, $urandom};
  end

  always @(negedge CLK) begin
    if (RST) begin
      hold = 0;
    end else begin
      if (SpMVLD && SpMRDY && SpMBUS[BW+1:BW] == 2'b00) begin
        issued = 0; popped = 0; seen_data = 0;
      end
      if (hold) begin
        chk("hold_vld", SpSVLD, 1'b1);
        chk("hold_bus", SpSBUS, hold_bus);
      end
      if (RD) begin
        chk("credit", (issued - popped) < FD, 1'b1);
        issued++;
        if (rdq.size() == 0) flag("rd_unexpected");
        else chk("rd_addr", RD_ADDR, rdq.pop_front());
      end
      if (WR) begin
        if (wrq.size() == 0) flag("wr_unexpected");
        else chk("wr_addr_mask_data", {WR_ADDR, MASK, WR_DATA}, wrq.pop_front());
      end
      if (SpSVLD && SpSRDY) begin
        if (sbq.size() == 0) flag("rsp_unexpected");
        else chk("rsp", SpSBUS, sbq.pop_front());
        if (SpSBUS[BW+1]) begin
          popped++;
          if (!seen_data) first_c = cyc;
          seen_data = 1;
          last_c = cyc;
        end
      end
      hold = SpSVLD && !SpSRDY;
      hold_bus = SpSBUS;
    end
  end

  task automatic send(input logic [65:0] b);
    int n;
    n = 0;
    SpMBUS = b;
    SpMVLD = 1'b1;
    @(negedge CLK);
    while (!SpMRDY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!SpMRDY) flag("req_accept_timeout");
    @(posedge CLK);
    #1;
    SpMVLD = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || rdq.size() != 0 || wrq.size() != 0) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    if (sbq.size() != 0 || rdq.size() != 0 || wrq.size() != 0) begin
      flag("drain_timeout");
      sbq.delete(); rdq.delete(); wrq.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] mode, input logic [3:0] len,
                          input logic [14:0] id, input logic [7:0] bm);
    logic [63:0] d[16];
    logic [63:0] m;
    for (int k = 0; k <= int'(len); k++) begin
      d[k] = {$urandom, $urandom};
      m = '1;
      if (k == 0) for (int b = 0; b < 8; b++) m[b*8 +: 8] = bm[b] ? 8'hFF : 8'h00;
      wrq.push_back({beat_addr(a, mode, len, k), m, d[k]});
    end
    sbq.push_back({2'b00, id_pay(id)});
    send(hdr(2'b01, a, len, mode, id, bm));
    for (int k = 0; k <= int'(len); k++) send({(k == int'(len)) ? 2'b11 : 2'b10, d[k]});
    wait_drain();
  endtask

  task automatic read_start(input logic [31:0] a, input logic [1:0] mode, input logic [3:0] len,
                            input logic [14:0] id);
    logic [31:0] ba;
    sbq.push_back({2'b01, id_pay(id)});
    for (int k = 0; k <= int'(len); k++) begin
      ba = beat_addr(a, mode, len, k);
      rdq.push_back(ba);
      sbq.push_back({1'b1, k == int'(len), ram(ba)});
    end
    send(hdr(2'b00, a, len, mode, id, 8'h00));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] mode, input logic [3:0] len,
                         input logic [14:0] id);
    read_start(a, mode, len, id);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1; SpMVLD = 1'b0; SpMBUS = '0; SpSRDY = 1'b1; RD_DATA = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_mrdy", SpMRDY, 1'b0);
    chk("reset_svld", SpSVLD, 1'b0);
    chk("reset_rd", RD, 1'b0);
    chk("reset_wr", WR, 1'b0);
    @(posedge CLK); #1;

    rdy_mode = 1;
    do_write(32'h100, 2'b01, 4'd3, 15'h1234, 8'h0F);

    rdy_mode = 0;
    do_read(32'h200, 2'b01, 4'd7, 15'h0ABC);
    chk("gap_free_span", last_c - first_c, 7);

    rdy_mode = 3;
    read_start(32'h4000, 2'b01, 4'd15, 15'h0777);
    repeat (6) @(posedge CLK);
    #1 rdy_mode = 2;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("stall_rd", RD, 1'b0);
    @(posedge CLK);
    #1 rdy_mode = 3;
    wait_drain();

    rdy_mode = 0;
    do_read(32'h1018, 2'b10, 4'd3, 15'h0011);
    do_write(32'h1018, 2'b10, 4'd3, 15'h0022, 8'hA5);
    do_read(32'h0000_FFF8, 2'b01, 4'd1, 15'h0033);
    do_read(32'hFFFF_FFF8, 2'b01, 4'd1, 15'h0044);
    do_read(32'h2010, 2'b10, 4'd2, 15'h0055);
    do_read(32'h3008, 2'b00, 4'd2, 15'h0066);

    read_start(32'h5000, 2'b01, 4'd15, 15'h0099);
    n = 0;
    while (issued < 2 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (issued < 2) flag("reset_setup_timeout");
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    sbq.delete(); rdq.delete(); wrq.delete();
    @(negedge CLK);
    chk("midrst_svld", SpSVLD, 1'b0);
    chk("midrst_rd", RD, 1'b0);
    @(posedge CLK); #1;
    do_read(32'h6000, 2'b01, 4'd5, 15'h0123);

    for (int t = 0; t < 12; t++) begin
      rdy_mode = 1;
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 15'($urandom));
      else
        do_write($urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 15'($urandom),
                 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spartan2pram.md
Name: spartan2pram

Overview:
- Next-generation Spartan-bus slave that converts Spartan read/write bursts into a simple dual-ported RAM interface.
- Sits between a Spartan interconnect port and a pipelined block RAM.
- Generalises the earlier single-cycle bridge:
  - RAM read latency is configurable, with a credit-controlled response FIFO that absorbs SpSRDY backpressure without losing RAM data.
  - Full 32-bit address stepping.
  - New wrap-burst mode.

Parameters:
BWIDTH, 64, data width in bits; legal values 64, 128, 256; INC = BWIDTH/8 bytes per beat.
RD_LAT, 1, cycles from RD asserted to RD_DATA valid; legal range 1..4.
FDEPTH, RD_LAT+2, response FIFO entries, each BWIDTH+2 bits wide; must be >= RD_LAT+2.

Ports:
CLK  input  1  clock; all logic on the rising edge.
RST  input  1  synchronous active-high reset.
SpMBUS  input  BWIDTH+2  master request bus: [BWIDTH+1:BWIDTH] type, [BWIDTH-1:0] header or data.
SpMVLD  input  1  request valid.
SpMRDY  output  1  request accepted this cycle.
SpSBUS  output  BWIDTH+2  response bus; same type/payload split as SpMBUS.
SpSVLD  output  1  response valid.
SpSRDY  input  1  response accepted this cycle.
RD  output  1  RAM read strobe.
RD_ADDR  output  32  RAM read byte address.
RD_DATA  input  BWIDTH  RAM read data, valid RD_LAT cycles after RD.
WR  output  1  RAM write strobe.
WR_ADDR  output  32  RAM write byte address.
MASK  output  BWIDTH  per-bit write enable.
WR_DATA  output  BWIDTH  RAM write data; equals SpMBUS[BWIDTH-1:0].

Behaviour:
- Request type codes: 00 = read header, 01 = write header, 10 = write data, 11 = last write data.
- Header fields:
  - [31:0] byte address ADDR.
  - [35:32] LEN; beats = LEN+1.
  - [40:39] MODE: 00 fixed, 01 increment, 10 wrap, 11 treated as increment.
  - [BWIDTH-BWIDTH/8-1:41] ID.
  - [BWIDTH-1:BWIDTH-BWIDTH/8] BMASK, byte mask for the first write beat.
- Address step per beat:
  - fixed: address unchanged.
  - increment: addr + INC, full 32-bit carry, wraps at 2^32.
  - wrap: W = (LEN+1)*INC. Next = (addr & ~(W-1)) | ((addr+INC) & (W-1)).
  - wrap with LEN+1 not a power of 2 behaves as increment.
- FSM states: IDLE, WDATA, WRESP, RBURST, RDRAIN.
- IDLE:
  - Write header (SpMVLD, type 01): SpMRDY=1; latch ADDR, MODE, LEN, ID, BMASK; go to WDATA.
  - Read header (type 00): accepted (SpMRDY=1) only when the FIFO has at least 1 free entry.
    - Push response header {01, payload with ID at [BWIDTH-BWIDTH/8-1:41] and zeros elsewhere}.
    - Load remaining = LEN+1; go to RBURST.
  - Type 1x beats in IDLE: SpMRDY=0 (stall).
- WDATA:
  - SpMRDY = SpMVLD whenever type[1]=1; WR=1 on each such beat.
  - MASK = BMASK expanded 8x on the first beat, all ones afterwards.
  - WR_ADDR steps after each beat.
  - A type 11 beat moves the FSM to WRESP.
- WRESP:
  - SpSVLD=1 with SpSBUS = {00, ID payload as above}; SpMRDY=0.
  - On SpSRDY go to IDLE.
- RBURST:
  - Credit rule: RD=1 when fifo_count + inflight < FDEPTH.
  - Each RD decrements remaining and steps RD_ADDR.
  - The RD that issues the final beat moves the FSM to RDRAIN.
  - First RD_ADDR is the latched ADDR.
- Read return pipeline:
  - RD_LAT-deep valid/last shift register.
  - When the valid bit emerges, push {1, last, RD_DATA} into the FIFO; the push never overflows because of the credit rule.
- RDRAIN: go to IDLE when inflight==0 and the FIFO is empty.
- Response output:
  - In read states, SpSVLD = FIFO not empty and SpSBUS = FIFO head; pop on SpSRDY.
  - FIFO push and pop in the same cycle is legal, including when full.
  - SpSVLD must hold and SpSBUS must stay stable until SpSRDY.
- Throughput: with SpSRDY held at 1, one read beat per cycle, and a LEN+1 burst completes in LEN+1+RD_LAT+2 cycles from header acceptance.
- Reset, and reset in the middle of an operation: the FSM goes to IDLE; FIFO, inflight, and the shift register are cleared. Data returning from the RAM after reset is discarded.
- Values the cycle after reset: SpMRDY=0, SpSVLD=0, RD=0, WR=0.
- Combinational outputs (SpMRDY, SpSVLD, RD, WR, MASK) are decoded from registered state and inputs.

Test Plan:
- Write, BWIDTH=64, ADDR=0x100, MODE=01, LEN=3, BMASK=0x0F, 4 data beats, last beat type 11 -> required response:
  - WR_ADDR 0x100, 0x108, 0x110, 0x118.
  - MASK 0x00000000FFFFFFFF on beat 0, then all ones.
  - Response {00, ID} held until SpSRDY.
- Read, RD_LAT=3, ADDR=0x200, LEN=7, SpSRDY=1 -> required response:
  - Header 01 with ID, then 8 beats of type 10, the last beat type 11, in order, gap-free.
  - RD_ADDR steps +8 per beat.
- Read, LEN=15, SpSRDY toggling 1/0 and held low for 10 cycles -> required response:
  - No data loss or reordering.
  - Never more than FDEPTH entries occupied; RD stalls while credits are exhausted.
- Wrap, ADDR=0x1018, LEN=3, MODE=10 -> required addresses 0x1018, 0x1000, 0x1008, 0x1010.
- Increment, ADDR=0x0000FFF8, LEN=1 -> required second address 0x00010000.
- RST asserted during RBURST with 2 reads in flight -> required response:
  - Next cycle SpSVLD=0 and RD=0.
  - Late RD_DATA is ignored.
  - A new read after reset returns the correct header and data.
